alu_seq: RTL and testbench

//  Multi-cycle ALU for the 8-bit RISC datapath; sits directly upstream of the

---
 rtl/alu_pkg.sv | 19 +
 rtl/seq_muldiv.sv | 61 ++++++
 rtl/alu_seq.sv | 108 ++++++++++
 tb/tb_alu_seq.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared opcode encodings and FSM state type for the sequential ALU.
package alu_pkg;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_SHL = 3'd5;
  localparam logic [2:0] OP_MUL = 3'd6;
  localparam logic [2:0] OP_DIV = 3'd7;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_DONE
  } state_t;

endpackage

// File: rtl/seq_muldiv.sv
// Iterative unsigned shift-add multiplier / restoring divider, one step per clock.
module seq_muldiv #(
  parameter int unsigned WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start_i,
  input  logic                 is_div_i,
  input  logic [WIDTH-1:0]     a_i,
  input  logic [WIDTH-1:0]     b_i,
  output logic                 last_o,
  output logic [2*WIDTH-1:0]   result_o
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  logic [CW-1:0]      cnt_q;
  logic               is_div_q;
  logic [WIDTH-1:0]   opnd_q;
  logic [2*WIDTH-1:0] p_q, p_d;

  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     rem_s;
  logic [WIDTH:0]     rem_n;
  logic               qbit;

  // MUL: p = {acc, multiplier}; DIV: p = {remainder, dividend/quotient}
  always_comb begin
    mul_sum = {1'b0, p_q[2*WIDTH-1:WIDTH]} + (p_q[0] ? {1'b0, opnd_q} : '0);
    rem_s   = {p_q[2*WIDTH-1:WIDTH], p_q[WIDTH-1]};
    qbit    = (rem_s >= {1'b0, opnd_q});
    rem_n   = qbit ? (rem_s - {1'b0, opnd_q}) : rem_s;
    if (is_div_q) begin
      p_d = {rem_n[WIDTH-1:0], p_q[WIDTH-2:0], qbit};
    end else begin
      p_d = {mul_sum, p_q[WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q    <= '0;
      is_div_q <= 1'b0;
      opnd_q   <= '0;
      p_q      <= '0;
    end else if (start_i) begin
      cnt_q    <= CW'(WIDTH);
      is_div_q <= is_div_i;
      opnd_q   <= is_div_i ? b_i : a_i;
      p_q      <= {{WIDTH{1'b0}}, (is_div_i ? a_i : b_i)};
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - CW'(1);
      p_q   <= p_d;
    end
  end

  // Result is taken from the final step's next value so it loads on the same edge.
  assign last_o   = (cnt_q == CW'(1));
  assign result_o = p_d;

endmodule

// File: rtl/alu_seq.sv
// Multi-cycle ALU: single-cycle logic/arith ops plus iterative MUL/DIV with start/busy/done.
module alu_seq
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [2:0]           opcode,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic [2*WIDTH-1:0]   result,
  output logic                 done,
  output logic                 busy,
  output logic                 zero,
  output logic                 carry,
  output logic                 dz
);

  state_t             state_q, state_d;
  logic [2*WIDTH-1:0] result_q, result_d;
  logic               zero_q, carry_q, carry_d, dz_q, dz_d;
  logic               load;
  logic               md_start, md_last;
  logic [2*WIDTH-1:0] md_result;
  logic [2*WIDTH-1:0] ext_a, ext_b, sum;
  logic               iterative;

  seq_muldiv #(.WIDTH(WIDTH)) u_muldiv (
    .clk      (clk),
    .rst      (rst),
    .start_i  (md_start),
    .is_div_i (opcode == OP_DIV),
    .a_i      (a),
    .b_i      (b),
    .last_o   (md_last),
    .result_o (md_result)
  );

  assign iterative = (opcode == OP_MUL) || ((opcode == OP_DIV) && (b != '0));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (start) state_d = iterative ? S_CALC : S_DONE;
      S_CALC: if (md_last) state_d = S_DONE;
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    done     = (state_q == S_DONE);
    busy     = (state_q == S_CALC);
    md_start = (state_q == S_IDLE) && start && iterative;
  end

  always_comb begin
    ext_a    = {{WIDTH{1'b0}}, a};
    ext_b    = {{WIDTH{1'b0}}, b};
    sum      = ext_a + ext_b;
    load     = 1'b0;
    result_d = result_q;
    carry_d  = 1'b0;
    dz_d     = 1'b0;
    if (state_q == S_IDLE && start && !iterative) begin
      load = 1'b1;
      unique case (opcode)
        OP_ADD: begin result_d = sum;           carry_d = sum[WIDTH]; end
        OP_SUB: begin result_d = ext_a - ext_b; carry_d = (a < b);    end
        OP_AND: result_d = ext_a & ext_b;
        OP_OR:  result_d = ext_a | ext_b;
        OP_XOR: result_d = ext_a ^ ext_b;
        OP_SHL: result_d = ext_a << b[2:0];
        default: begin result_d = '1; dz_d = 1'b1; end
      endcase
    end else if (state_q == S_CALC && md_last) begin
      load     = 1'b1;
      result_d = md_result;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result_q <= '0;
      zero_q   <= 1'b1;
      carry_q  <= 1'b0;
      dz_q     <= 1'b0;
    end else if (load) begin
      result_q <= result_d;
      zero_q   <= (result_d == '0);
      carry_q  <= carry_d;
      dz_q     <= dz_d;
    end
  end

  assign result = result_q;
  assign zero   = zero_q;
  assign carry  = carry_q;
  assign dz     = dz_q;

endmodule

// File: tb/tb_alu_seq.sv
// Directed self-checking bench for alu_seq.
module tb_alu_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [2:0]  opcode;
  logic [7:0]  a, b;
  logic [15:0] result;
  logic        done, busy, zero, carry, dz;

  int total = 0;
  int bad   = 0;

  alu_seq #(.WIDTH(8)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .opcode (opcode),
    .a      (a),
    .b      (b),
    .result (result),
    .done   (done),
    .busy   (busy),
    .zero   (zero),
    .carry  (carry),
    .dz     (dz)
  );

  always #5 clk = ~clk;

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; opcode = 3'd0; a = '0; b = '0;
    #12;
    total++; if (result !== 16'h0000) begin bad++; $display("FAIL reset_result got=%h exp=0000", result); end
    total++; if ({done, busy, zero, carry, dz} !== 5'b00100) begin bad++; $display("FAIL reset_flags got=%b exp=00100", {done, busy, zero, carry, dz}); end
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_add();
    @(negedge clk); start = 1'b1; opcode = 3'd0; a = 8'hF0; b = 8'h20;
    @(negedge clk); start = 1'b0;
    total++; if (done !== 1'b1) begin bad++; $display("FAIL add_done got=%b exp=1", done); end
    total++; if (result !== 16'h0110) begin bad++; $display("FAIL add_result got=%h exp=0110", result); end
    total++; if ({carry, zero, dz} !== 3'b100) begin bad++; $display("FAIL add_flags got=%b exp=100", {carry, zero, dz}); end
    @(negedge clk);
    total++; if (done !== 1'b0) begin bad++; $display("FAIL add_done_pulse got=%b exp=0", done); end
  endtask

  task automatic test_sub();
    @(negedge clk); start = 1'b1; opcode = 3'd1; a = 8'd3; b = 8'd5;
    @(negedge clk); start = 1'b0;
    total++; if (result !== 16'hFFFE) begin bad++; $display("FAIL sub_borrow_result got=%h exp=fffe", result); end
    total++; if ({carry, zero} !== 2'b10) begin bad++; $display("FAIL sub_borrow_flags got=%b exp=10", {carry, zero}); end
    @(negedge clk); start = 1'b1; opcode = 3'd1; a = 8'd7; b = 8'd7;
    @(negedge clk); start = 1'b0;
    total++; if (result !== 16'h0000) begin bad++; $display("FAIL sub_equal_result got=%h exp=0000", result); end
    total++; if ({carry, zero} !== 2'b01) begin bad++; $display("FAIL sub_equal_flags got=%b exp=01", {carry, zero}); end
    @(negedge clk);
  endtask

  task automatic test_logic();
    logic [2:0]  ops [4]  = '{3'd2, 3'd3, 3'd4, 3'd5};
    logic [7:0]  va  [4]  = '{8'hF0, 8'hF0, 8'hF0, 8'hFF};
    logic [7:0]  vb  [4]  = '{8'h3C, 8'h3C, 8'h3C, 8'h0F};
    logic [15:0] exp [4]  = '{16'h0030, 16'h00FC, 16'h00CC, 16'h7F80};
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); start = 1'b1; opcode = ops[i]; a = va[i]; b = vb[i];
      @(negedge clk); start = 1'b0;
      total++; if (result !== exp[i]) begin bad++; $display("FAIL logic_op%0d_result got=%h exp=%h", ops[i], result, exp[i]); end
      total++; if ({done, carry, dz} !== 3'b100) begin bad++; $display("FAIL logic_op%0d_flags got=%b exp=100", ops[i], {done, carry, dz}); end
      @(negedge clk);
    end
  endtask

  task automatic test_mul();
    int busy_cycles = 0;
    int done_cyc = -1;
    @(negedge clk); start = 1'b1; opcode = 3'd6; a = 8'hFF; b = 8'hFF;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk); start = 1'b0;
      if (busy) busy_cycles++;
      if (done && done_cyc < 0) begin
        done_cyc = c;
        total++; if (result !== 16'hFE01) begin bad++; $display("FAIL mul_result got=%h exp=fe01", result); end
        total++; if ({carry, dz, zero} !== 3'b000) begin bad++; $display("FAIL mul_flags got=%b exp=000", {carry, dz, zero}); end
      end
    end
    total++; if (done_cyc !== 9) begin bad++; $display("FAIL mul_latency got=%0d exp=9", done_cyc); end
    total++; if (busy_cycles !== 8) begin bad++; $display("FAIL mul_busy_cycles got=%0d exp=8", busy_cycles); end
  endtask

  task automatic test_div();
    int done_cyc = -1;
    @(negedge clk); start = 1'b1; opcode = 3'd7; a = 8'd100; b = 8'd7;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk); start = 1'b0;
      if (done && done_cyc < 0) begin
        done_cyc = c;
        total++; if (result !== 16'h020E) begin bad++; $display("FAIL div_result got=%h exp=020e", result); end
        total++; if (dz !== 1'b0) begin bad++; $display("FAIL div_dz got=%b exp=0", dz); end
      end
    end
    total++; if (done_cyc !== 9) begin bad++; $display("FAIL div_latency got=%0d exp=9", done_cyc); end
    @(negedge clk); start = 1'b1; opcode = 3'd7; a = 8'd9; b = 8'd0;
    @(negedge clk); start = 1'b0;
    total++; if ({done, busy} !== 2'b10) begin bad++; $display("FAIL divz_done_busy got=%b exp=10", {done, busy}); end
    total++; if (result !== 16'hFFFF) begin bad++; $display("FAIL divz_result got=%h exp=ffff", result); end
    total++; if ({dz, carry} !== 2'b10) begin bad++; $display("FAIL divz_flags got=%b exp=10", {dz, carry}); end
    @(negedge clk);
  endtask

  task automatic test_ignore_start();
    int dones = 0;
    int done_cyc = -1;
    @(negedge clk); start = 1'b1; opcode = 3'd6; a = 8'd12; b = 8'd12;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (c == 3) begin start = 1'b1; opcode = 3'd0; a = 8'd1; b = 8'd1; end
      if (done) begin dones++; done_cyc = c; end
    end
    total++; if (dones !== 1) begin bad++; $display("FAIL ignore_done_count got=%0d exp=1", dones); end
    total++; if (done_cyc !== 9) begin bad++; $display("FAIL ignore_latency got=%0d exp=9", done_cyc); end
    total++; if (result !== 16'h0090) begin bad++; $display("FAIL ignore_result got=%h exp=0090", result); end
  endtask

  task automatic test_back_to_back();
    @(negedge clk); start = 1'b1; opcode = 3'd0; a = 8'd1; b = 8'd2;
    @(negedge clk);
    total++; if ({done, result} !== {1'b1, 16'h0003}) begin bad++; $display("FAIL b2b_first got=%b/%h exp=1/0003", done, result); end
    a = 8'd5; b = 8'd5;
    @(negedge clk);
    total++; if ({done, result} !== {1'b0, 16'h0003}) begin bad++; $display("FAIL b2b_ignored_in_done got=%b/%h exp=0/0003", done, result); end
    @(negedge clk); start = 1'b0;
    total++; if ({done, result} !== {1'b1, 16'h000A}) begin bad++; $display("FAIL b2b_second got=%b/%h exp=1/000a", done, result); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int dones = 0;
    @(negedge clk); start = 1'b1; opcode = 3'd6; a = 8'd12; b = 8'd12;
    for (int c = 1; c <= 4; c++) begin @(negedge clk); start = 1'b0; end
    #2 rst = 1'b1;
    #1;
    total++; if (result !== 16'h0000) begin bad++; $display("FAIL rstmid_result got=%h exp=0000", result); end
    total++; if ({done, busy, zero, carry, dz} !== 5'b00100) begin bad++; $display("FAIL rstmid_flags got=%b exp=00100", {done, busy, zero, carry, dz}); end
    @(negedge clk); rst = 1'b0;
    for (int c = 0; c < 10; c++) begin @(negedge clk); if (done) dones++; end
    total++; if (dones !== 0) begin bad++; $display("FAIL rstmid_no_done got=%0d exp=0", dones); end
    start = 1'b1; opcode = 3'd0; a = 8'd2; b = 8'd2;
    @(negedge clk); start = 1'b0;
    total++; if ({done, result} !== {1'b1, 16'h0004}) begin bad++; $display("FAIL rstmid_add got=%b/%h exp=1/0004", done, result); end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_logic();
    test_mul();
    test_div();
    test_ignore_start();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
